// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush controller for a 5-stage RV32I pipeline. Handles
//            load-use hazards, EX-resolved jumps/branches and multi-cycle
//            data-memory waits, with a memory-timeout error state and a
//            saturating load-use stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead_id_ex_i,
  input  logic [4:0]        Rd_id_ex_i,
  input  logic [4:0]        Rs1_if_id_i,
  input  logic [4:0]        Rs2_if_id_i,
  input  logic              use_rs1_i,
  input  logic              use_rs2_i,
  input  logic              jump_taken_ex_i,
  input  logic              mem_req_i,
  input  logic              mem_ready_i,
  output logic              pc_en_o,
  output logic              if_id_en_o,
  output logic              if_id_flush_o,
  output logic              id_ex_en_o,
  output logic              id_ex_flush_o,
  output logic              ex_mem_en_o,
  output logic              mem_wb_en_o,
  output logic              mem_wb_flush_o,
  output logic              mem_err_o,
  output logic [PERF_W-1:0] lu_stall_cnt_o
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  // Last wait count value that may still be followed by another stalled cycle
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  WAIT_ONE  = CNT_W'(1);
  localparam logic [PERF_W-1:0] PERF_MAX  = '1;
  localparam logic [PERF_W-1:0] PERF_ONE  = PERF_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             err_set;
  logic             memstall;
  logic             lu_hazard;
  logic             lu_apply;

  // Hazard detection: memory stall and load-use dependency of ID on the load in EX
  always_comb begin
    memstall  = ((state == ST_RUN) && mem_req_i && !mem_ready_i) ||
                ((state == ST_MEM_WAIT) && !mem_ready_i);
    lu_hazard = MemRead_id_ex_i && (Rd_id_ex_i != 5'd0) &&
                (((Rs1_if_id_i == Rd_id_ex_i) && use_rs1_i) ||
                 ((Rs2_if_id_i == Rd_id_ex_i) && use_rs2_i));
    // Load-use only takes effect when nothing of higher priority overrides it
    lu_apply  = (state != ST_ERROR) && !memstall && !jump_taken_ex_i && lu_hazard;
  end

  // Pipeline register controls, priority ERROR > memstall > jump > load-use > normal
  always_comb begin
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_en_o     = 1'b1;
    id_ex_flush_o  = 1'b0;
    ex_mem_en_o    = 1'b1;
    mem_wb_en_o    = 1'b1;
    mem_wb_flush_o = 1'b0;
    if (!rst_n || (state == ST_ERROR)) begin
      pc_en_o     = 1'b0;
      if_id_en_o  = 1'b0;
      id_ex_en_o  = 1'b0;
      ex_mem_en_o = 1'b0;
      mem_wb_en_o = 1'b0;
    end else if (memstall) begin
      // Freeze everything; WB gets a bubble so the stalled load is not retired twice
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_en_o    = 1'b0;
      mem_wb_en_o    = 1'b0;
      mem_wb_flush_o = 1'b1;
    end else if (jump_taken_ex_i) begin
      // PC takes the target, the two younger wrong-path instructions are killed
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (lu_apply) begin
      // Hold PC and IF/ID, insert a bubble into EX while the load moves on
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  // Next state and wait counter for the memory-wait / timeout tracking
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_set      = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_req_i && !mem_ready_i) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = WAIT_ONE;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready_i) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_ERROR;
          err_set   = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_ONE;
        end
      end
      ST_ERROR: begin
        state_nxt = ST_ERROR;
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // State, counters and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      wait_cnt       <= '0;
      mem_err_o      <= 1'b0;
      lu_stall_cnt_o <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_err_o <= mem_err_o | err_set;
      if (lu_apply && (lu_stall_cnt_o != PERF_MAX)) begin
        lu_stall_cnt_o <= lu_stall_cnt_o + PERF_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Self-checking bench for pipe_hazard_ctrl: table vectors, directed
//            multi-cycle sequences and randomized stimulus against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 5;
  localparam int PERF_W      = 4;
  localparam int PERF_SAT    = (1 << PERF_W) - 1;

  localparam logic [7:0] C_NORM  = 8'b1101_0110;
  localparam logic [7:0] C_LU    = 8'b0001_1110;
  localparam logic [7:0] C_JMP   = 8'b1111_1110;
  localparam logic [7:0] C_MSTL  = 8'b0000_0001;
  localparam logic [7:0] C_FROZE = 8'b0000_0000;

  typedef struct packed {
    logic       memread;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       jump;
    logic       req;
    logic       ready;
  } vec_t;

  typedef struct packed {
    vec_t       v;
    logic [7:0] exp;
  } tab_t;

  logic clk;
  logic rst_n;
  vec_t cur;

  logic              MemRead_id_ex_i;
  logic [4:0]        Rd_id_ex_i, Rs1_if_id_i, Rs2_if_id_i;
  logic              use_rs1_i, use_rs2_i, jump_taken_ex_i, mem_req_i, mem_ready_i;
  logic              pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o;
  logic              ex_mem_en_o, mem_wb_en_o, mem_wb_flush_o, mem_err_o;
  logic [PERF_W-1:0] lu_stall_cnt_o;
  logic [7:0]        ctrl;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_err;
  int m_waits;
  int m_cnt;

  assign MemRead_id_ex_i = cur.memread;
  assign Rd_id_ex_i      = cur.rd;
  assign Rs1_if_id_i     = cur.rs1;
  assign Rs2_if_id_i     = cur.rs2;
  assign use_rs1_i       = cur.u1;
  assign use_rs2_i       = cur.u2;
  assign jump_taken_ex_i = cur.jump;
  assign mem_req_i       = cur.req;
  assign mem_ready_i     = cur.ready;
  assign ctrl = {pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
                 ex_mem_en_o, mem_wb_en_o, mem_wb_flush_o};

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W),
    .PERF_W     (PERF_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .MemRead_id_ex_i(MemRead_id_ex_i),
    .Rd_id_ex_i     (Rd_id_ex_i),
    .Rs1_if_id_i    (Rs1_if_id_i),
    .Rs2_if_id_i    (Rs2_if_id_i),
    .use_rs1_i      (use_rs1_i),
    .use_rs2_i      (use_rs2_i),
    .jump_taken_ex_i(jump_taken_ex_i),
    .mem_req_i      (mem_req_i),
    .mem_ready_i    (mem_ready_i),
    .pc_en_o        (pc_en_o),
    .if_id_en_o     (if_id_en_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_en_o     (id_ex_en_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .ex_mem_en_o    (ex_mem_en_o),
    .mem_wb_en_o    (mem_wb_en_o),
    .mem_wb_flush_o (mem_wb_flush_o),
    .mem_err_o      (mem_err_o),
    .lu_stall_cnt_o (lu_stall_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic memread, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic jump,
                              input logic req, input logic ready);
    vec_t v;
    v.memread = memread; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.u1 = u1; v.u2 = u2; v.jump = jump; v.req = req; v.ready = ready;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // model: does ID really depend on the load in EX
  function automatic bit m_lu(input vec_t v);
    return v.memread && (v.rd != 0) &&
           ((v.rs1 == v.rd && v.u1) || (v.rs2 == v.rd && v.u2));
  endfunction

  // model: memory stall is "a wait is in progress and still not ready", or a new miss
  function automatic bit m_stall(input vec_t v);
    if (m_waits > 0) return !v.ready;
    return v.req && !v.ready;
  endfunction

  function automatic logic [7:0] m_ctrl(input vec_t v);
    if (m_err)        return C_FROZE;
    if (m_stall(v))   return C_MSTL;
    if (v.jump)       return C_JMP;
    if (m_lu(v))      return C_LU;
    return C_NORM;
  endfunction

  task automatic m_step(input vec_t v);
    if (m_err) return;
    if (m_stall(v)) begin
      m_waits++;
      if (m_waits >= MEM_TIMEOUT) m_err = 1'b1;
    end else begin
      m_waits = 0;
      if (!v.jump && m_lu(v) && m_cnt < PERF_SAT) m_cnt++;
    end
  endtask

  task automatic m_reset();
    m_err = 1'b0; m_waits = 0; m_cnt = 0;
  endtask

  // one clock cycle: drive at negedge, compare mid-low, model advances at posedge
  task automatic cycle(input vec_t v, input bit chk_tab, input logic [7:0] exp_tab,
                       input string nm);
    @(negedge clk);
    cur = v;
    #2;
    check({nm, "/ctrl_model"}, 32'(ctrl), 32'(m_ctrl(v)));
    if (chk_tab) check({nm, "/ctrl"}, 32'(ctrl), 32'(exp_tab));
    check({nm, "/mem_err"}, 32'(mem_err_o), 32'(m_err));
    check({nm, "/lu_cnt"}, 32'(lu_stall_cnt_o), 32'(m_cnt));
    @(posedge clk);
    m_step(v);
  endtask

  // asynchronous reset asserted and released away from clock edges
  task automatic async_reset(input string nm);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({nm, "/rst_ctrl"}, 32'(ctrl), 32'(C_FROZE));
    check({nm, "/rst_err"}, 32'(mem_err_o), 32'd0);
    check({nm, "/rst_cnt"}, 32'(lu_stall_cnt_o), 32'd0);
    m_reset();
    @(posedge clk);
    #1;
    check({nm, "/rst_hold_ctrl"}, 32'(ctrl), 32'(C_FROZE));
    #2 rst_n = 1'b1;
  endtask

  tab_t tab [10];
  vec_t idle, lu, rv;

  initial begin
    idle = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lu   = mk(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    tab[0] = '{v: idle, exp: C_NORM};
    tab[1] = '{v: lu, exp: C_LU};
    tab[2] = '{v: mk(1'b1, 5'd0, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), exp: C_NORM};
    tab[3] = '{v: mk(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), exp: C_NORM};
    tab[4] = '{v: mk(1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), exp: C_LU};
    tab[5] = '{v: mk(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), exp: C_NORM};
    tab[6] = '{v: mk(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), exp: C_JMP};
    tab[7] = '{v: mk(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1), exp: C_LU};
    tab[8] = '{v: mk(1'b1, 5'd9, 5'd9, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), exp: C_NORM};
    tab[9] = '{v: mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1), exp: C_JMP};

    cur   = idle;
    rst_n = 1'b0;
    m_reset();
    #12;
    check("reset/ctrl", 32'(ctrl), 32'(C_FROZE));
    check("reset/mem_err", 32'(mem_err_o), 32'd0);
    check("reset/lu_cnt", 32'(lu_stall_cnt_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table vectors, all evaluated from the RUN state
    for (int i = 0; i < 10; i++) begin
      cycle(tab[i].v, 1'b1, tab[i].exp, $sformatf("tab%0d", i));
    end

    // load-use stall lasts one cycle once the load has moved out of EX
    cycle(lu, 1'b1, C_LU, "lu_once");
    cycle(mk(1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, C_NORM, "lu_after");

    // three-cycle memory wait, then release
    for (int i = 0; i < 3; i++) begin
      cycle(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, C_MSTL,
            $sformatf("mwait%0d", i));
    end
    cycle(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b1, C_NORM, "mwait_rel");
    cycle(idle, 1'b1, C_NORM, "mwait_idle");

    // jump pending under a memory stall is held, then acted on at release
    cycle(mk(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, C_MSTL, "jmp_held");
    cycle(mk(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1), 1'b1, C_JMP, "jmp_rel");

    // counter saturation
    for (int i = 0; i < 20; i++) begin
      cycle(lu, 1'b1, C_LU, $sformatf("sat%0d", i));
    end
    #1;
    check("sat/lu_cnt", 32'(lu_stall_cnt_o), 32'(PERF_SAT));

    // randomized stimulus against the model
    async_reset("pre_rand");
    for (int i = 0; i < 3000; i++) begin
      rv.memread = ($urandom_range(0, 1) == 1);
      rv.rd      = 5'($urandom_range(0, 3));
      rv.rs1     = 5'($urandom_range(0, 3));
      rv.rs2     = 5'($urandom_range(0, 3));
      rv.u1      = ($urandom_range(0, 1) == 1);
      rv.u2      = ($urandom_range(0, 1) == 1);
      rv.jump    = ($urandom_range(0, 4) == 0);
      rv.req     = ($urandom_range(0, 2) == 0);
      rv.ready   = ($urandom_range(0, 3) != 0);
      cycle(rv, 1'b0, 8'h00, $sformatf("rand%0d", i));
    end

    // memory timeout: error after the last allowed stalled cycle, then frozen
    async_reset("pre_tmo");
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      cycle(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, C_MSTL,
            $sformatf("tmo%0d", i));
    end
    #1;
    check("tmo/mem_err", 32'(mem_err_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(mk(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1), 1'b1, C_FROZE,
            $sformatf("err%0d", i));
    end
    cycle(idle, 1'b1, C_FROZE, "err_idle");

    // asynchronous reset recovers normal operation
    async_reset("recover");
    cycle(idle, 1'b1, C_NORM, "post_rst_idle");
    cycle(lu, 1'b1, C_LU, "post_rst_lu");
    cycle(idle, 1'b1, C_NORM, "post_rst_idle2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV32I pipeline.
- Drives enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three hazard classes: load-use hazards, control hazards from jumps or taken branches resolved in EX, and multi-cycle data-memory waits.
- Adds a data-memory timeout error state and a saturating load-use stall counter.

Parameters:
- MEM_TIMEOUT, 16, maximum number of consecutive MEM_WAIT cycles before the ERROR state is entered (must be at least 2).
- CNT_W, 5, width of the wait counter (2^CNT_W must be at least MEM_TIMEOUT).
- PERF_W, 16, width of the load-use stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MemRead_id_ex_i  in  1  instruction in EX is a load.
- Rd_id_ex_i  in  5  destination register of the instruction in EX.
- Rs1_if_id_i  in  5  rs1 of the instruction in ID.
- Rs2_if_id_i  in  5  rs2 of the instruction in ID.
- use_rs1_i  in  1  instruction in ID reads rs1.
- use_rs2_i  in  1  instruction in ID reads rs2.
- jump_taken_ex_i  in  1  jal, jalr or taken branch resolved in EX this cycle.
- mem_req_i  in  1  instruction in MEM accesses data memory.
- mem_ready_i  in  1  data memory completes the access this cycle.
- pc_en_o  out  1  PC update enable.
- if_id_en_o  out  1  IF/ID capture enable.
- if_id_flush_o  out  1  IF/ID clear to NOP.
- id_ex_en_o  out  1  ID/EX capture enable.
- id_ex_flush_o  out  1  ID/EX clear to bubble (all control bits 0).
- ex_mem_en_o  out  1  EX/MEM capture enable.
- mem_wb_en_o  out  1  MEM/WB capture enable.
- mem_wb_flush_o  out  1  MEM/WB clear (RegWrite forced to 0).
- mem_err_o  out  1  sticky data-memory timeout flag.
- lu_stall_cnt_o  out  PERF_W  saturating count of load-use stall cycles.

Behaviour:
- States: RUN, MEM_WAIT, ERROR. The state is registered; all control outputs are combinational from state and inputs. The counters and mem_err_o are registered.
- Reset (asynchronous, takes effect mid-operation):
  - state = RUN, wait_cnt = 0, mem_err_o = 0, lu_stall_cnt_o = 0.
  - While rst_n = 0, all enables = 0 and all flushes = 0.
- memstall = (state == RUN and mem_req_i and not mem_ready_i) or (state == MEM_WAIT and not mem_ready_i).
- Priority for control outputs: ERROR > memstall > jump > load-use > normal.
- Normal operation: all enables = 1, all flushes = 0.
- ERROR state: all enables = 0 and all flushes = 0, until reset.
- memstall:
  - pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o and mem_wb_en_o = 0.
  - mem_wb_flush_o = 1, so WB sees a bubble.
  - if_id_flush_o and id_ex_flush_o = 0.
  - A pending jump or load-use condition is not acted on. It is re-evaluated on the release cycle because its inputs are held.
- jump (jump_taken_ex_i):
  - pc_en_o = 1 (PC loads the target).
  - if_id_flush_o = 1 and id_ex_flush_o = 1.
  - All other enables = 1.
  - The load-use condition is ignored because the instruction in ID is wrong-path.
- load-use:
  - Condition: MemRead_id_ex_i, Rd_id_ex_i != 0, and ((Rs1_if_id_i == Rd_id_ex_i and use_rs1_i) or (Rs2_if_id_i == Rd_id_ex_i and use_rs2_i)).
  - pc_en_o = 0, if_id_en_o = 0, id_ex_flush_o = 1.
  - ex_mem_en_o and mem_wb_en_o = 1.
  - Exactly one stall cycle results, because the load leaves EX on the next edge.
- Transitions:
  - RUN -> MEM_WAIT when mem_req_i and not mem_ready_i; wait_cnt <= 1.
  - MEM_WAIT -> RUN when mem_ready_i. On that cycle memstall = 0, so the pipeline advances and the load data is captured into MEM/WB. wait_cnt <= 0.
  - MEM_WAIT, not mem_ready_i, wait_cnt == MEM_TIMEOUT-1 -> ERROR; mem_err_o <= 1.
  - MEM_WAIT otherwise: wait_cnt <= wait_cnt + 1.
  - ERROR is left only by reset.
- mem_ready_i in the same cycle as mem_req_i in RUN means a zero-wait access: no stall, no state change.
- lu_stall_cnt_o increments on every cycle where the load-use stall is actually applied (not overridden by a higher priority). It saturates at 2^PERF_W-1 with no wrap.

Test Plan:
- Reset, then idle inputs -> all enables 1, all flushes 0, mem_err_o 0, lu_stall_cnt_o 0.
- Load-use stall: MemRead_id_ex_i = 1, Rd_id_ex_i = 5, Rs2_if_id_i = 5, use_rs2_i = 1 for one cycle -> pc_en_o = 0, if_id_en_o = 0, id_ex_flush_o = 1 for exactly 1 cycle; lu_stall_cnt_o = 1.
- Load-use filtering: same stimulus with Rd_id_ex_i = 0, or with use_rs2_i = 0 -> no stall; lu_stall_cnt_o unchanged.
- Jump over load-use: jump_taken_ex_i = 1 together with the load-use condition -> if_id_flush_o = 1, id_ex_flush_o = 1, pc_en_o = 1; lu_stall_cnt_o unchanged.
- Memory wait: mem_req_i = 1 and mem_ready_i = 0 for 3 cycles, then mem_ready_i = 1 -> 3 cycles with all enables 0 and mem_wb_flush_o = 1; on the ready cycle all enables = 1; state returns to RUN.
- Timeout and reset: mem_req_i = 1 and mem_ready_i = 0 held for MEM_TIMEOUT cycles (16) -> mem_err_o rises after the 16th stalled cycle and the pipeline stays frozen with mem_ready_i later = 1. Then pulse rst_n low asynchronously mid-cycle -> mem_err_o = 0, enables 0 during reset, normal operation after release.
